// File: rtl/packet_tx_serializer.sv
// -----------------------------------------------------------------------------
// packet_tx_serializer
//
// Purpose:
//   Accepts one whole packet (header/addr/data) on a valid/ready bundle port
//   and emits it on a narrow link as NBEATS beats with valid/ready/last.
//   Beat order is header, addr, data. Fields wider than one beat go out
//   least-significant slice first. One packet is held in a staging register.
//   A new packet can be captured on the same edge as the last-beat
//   handshake, so back-to-back packets leave no idle cycle between them.
//
// Ports:
//   clock, reset_n          single rising-edge clock, async active-low reset
//   inPacket_valid/ready    bundle handshake (ready is combinational)
//   inPacket_tx_header      HDR_W  packet header
//   inPacket_tx_addr        ADDR_W packet address
//   inPacket_tx_data        DATA_W packet data
//   outBeat_valid/ready     beat handshake
//   outBeat_data            BEAT_W beat payload
//   outBeat_last            final beat of the packet
//   outBeat_idx             index of the current beat within the packet
//   pkt_count               CNT_W  packets fully sent since reset (wraps)
//   busy                    a packet is in flight
// -----------------------------------------------------------------------------
module packet_tx_serializer #(
    parameter  int HDR_W  = 16,
    parameter  int ADDR_W = 16,
    parameter  int DATA_W = 32,
    parameter  int BEAT_W = 16,
    parameter  int CNT_W  = 16,
    localparam int NBEATS = (HDR_W + ADDR_W + DATA_W) / BEAT_W,
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inPacket_valid,
    output logic              inPacket_ready,
    input  logic [HDR_W-1:0]  inPacket_tx_header,
    input  logic [ADDR_W-1:0] inPacket_tx_addr,
    input  logic [DATA_W-1:0] inPacket_tx_data,
    output logic              outBeat_valid,
    input  logic              outBeat_ready,
    output logic [BEAT_W-1:0] outBeat_data,
    output logic              outBeat_last,
    output logic [IDX_W-1:0]  outBeat_idx,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);

    localparam int TOT_W = HDR_W + ADDR_W + DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q;
    logic [TOT_W-1:0]   stage_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BEAT_W-1:0]  data_q;
    logic               last_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [TOT_W-1:0]   bundle_d;
    logic [IDX_W-1:0]   idx_d;
    logic               beat_hs;
    logic               load;

    // Header sits in the low bits so beat k is simply slice k of the bundle.
    assign bundle_d = {inPacket_tx_data, inPacket_tx_addr, inPacket_tx_header};
    assign idx_d    = idx_q + 1'b1;
    assign beat_hs  = valid_q & outBeat_ready;

    // Ready is combinational from outBeat_ready so the next packet can be
    // taken on the very edge that retires the current last beat.
    assign inPacket_ready = (state_q == IDLE) | ((state_q == SEND) & last_q & outBeat_ready);
    assign load           = inPacket_valid & inPacket_ready;

    // Single FSM process; every output-facing value is a register, so there is
    // no combinational path from inPacket_* to outBeat_*.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the staging register is reset as well, so a dropped packet
            // can never leak into a later beat and outBeat_data is 0 after reset.
            state_q <= IDLE;
            stage_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge values of the registers it reads.
            if (beat_hs && last_q) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load) begin
                // IDLE capture, or a new packet on the last-beat handshake.
                state_q <= SEND;
                stage_q <= bundle_d;
                idx_q   <= '0;
                data_q  <= bundle_d[BEAT_W-1:0];
                last_q  <= (NBEATS == 1);
                valid_q <= 1'b1;
            end else if (beat_hs) begin
                if (last_q) begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    data_q  <= '0;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    idx_q  <= idx_d;
                    data_q <= stage_q[int'(idx_d) * BEAT_W +: BEAT_W];
                    last_q <= (idx_d == LAST_IDX);
                end
            end
            // Without a handshake everything holds: beats stay stable under
            // backpressure and the staging register is never touched mid-packet.
        end
    end

    assign outBeat_valid = valid_q;
    assign outBeat_data  = data_q;
    assign outBeat_last  = last_q;
    assign outBeat_idx   = idx_q;
    assign pkt_count     = cnt_q;
    assign busy          = (state_q == SEND);

endmodule
